fsic_io_serdes_tx_lane: RTL

// Parametrised, single-clock TX serializer for the FSIC chip-to-chip link. Buffers AXIS beats from the

---
 rtl/fsic_io_serdes_tx_lane.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/fsic_io_serdes_tx_lane.sv
// TX serializer lane for the FSIC chip-to-chip link: buffers AXIS beats in a small FIFO and
// shifts each beat out over pCLK_RATIO ioclk phases with link training and remote flow control.
module fsic_io_serdes_tx_lane #(
  parameter int pDATA_WIDTH   = 32,
  parameter int pCLK_RATIO    = 4,
  parameter int pTXFIFO_DEPTH = 4,
  parameter int pTRAIN_FRAMES = 8,
  localparam int pSERIALIO_WIDTH = pDATA_WIDTH / pCLK_RATIO + 4
) (
  input  logic                       ioclk,
  input  logic                       axis_rst,
  input  logic                       txen_ctl,
  input  logic                       remote_tready,
  input  logic                       local_rx_ready,
  input  logic [pDATA_WIDTH-1:0]     s_tdata,
  input  logic [pDATA_WIDTH/8-1:0]   s_tstrb,
  input  logic [pDATA_WIDTH/8-1:0]   s_tkeep,
  input  logic [1:0]                 s_tid,
  input  logic [1:0]                 s_tuser,
  input  logic                       s_tlast,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  output logic [pSERIALIO_WIDTH-1:0] serial_txd,
  output logic                       txen,
  output logic [1:0]                 link_state,
  output logic [31:0]                tx_frame_cnt
);

  localparam int NL = pDATA_WIDTH / pCLK_RATIO;
  localparam int SB = pDATA_WIDTH / 8;
  localparam int PW = $clog2(pCLK_RATIO);
  localparam int AW = (pTXFIFO_DEPTH > 2) ? $clog2(pTXFIFO_DEPTH) : 1;
  localparam int CW = (pTRAIN_FRAMES > 1) ? $clog2(pTRAIN_FRAMES) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRAIN = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  typedef struct packed {
    logic [pDATA_WIDTH-1:0] data;
    logic [SB-1:0]          strb;
    logic [SB-1:0]          keep;
    logic [3:0]             idu;
    logic                   last;
  } beat_t;

  typedef struct packed {
    beat_t beat;
    logic  valid;
    logic  ready;
    logic  parity;
  } frame_t;

  // Parity makes the XOR over every transmitted bit of the frame come out to zero.
  function automatic frame_t makeFrame(input beat_t b, input logic valid, input logic ready);
    frame_t f;
    f.beat   = b;
    f.valid  = valid;
    f.ready  = ready;
    f.parity = ^{b, valid, ready};
    return f;
  endfunction

  function automatic beat_t trainBeat();
    beat_t b;
    b = '0;
    for (int j = 0; j < NL; j++) b.data[j*pCLK_RATIO] = 1'b1;
    return b;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [CW-1:0] trainCnt_q, trainCnt_d;
  frame_t        frame_q, frame_d;
  logic [31:0]   frameCnt_q;
  beat_t         mem_q [pTXFIFO_DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [AW:0]   count_q;
  logic          full, empty, push, pop, boundary;
  beat_t         inBeat;
  frame_t        trainFrame;

  assign full     = (count_q == (AW+1)'(pTXFIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign s_tready = !axis_rst && !full;
  assign push     = s_tvalid && s_tready;
  assign inBeat   = '{data: s_tdata, strb: s_tstrb, keep: s_tkeep,
                      idu: {s_tid, s_tuser}, last: s_tlast};
  assign boundary   = (ph_q == PW'(pCLK_RATIO - 1));
  assign trainFrame = makeFrame(trainBeat(), 1'b0, local_rx_ready);

  always_ff @(posedge ioclk) begin
    if (push) mem_q[wrPtr_q] <= inBeat;
  end

  always_ff @(posedge ioclk) begin
    if (axis_rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= (wrPtr_q == AW'(pTXFIFO_DEPTH - 1)) ? '0 : wrPtr_q + AW'(1);
      if (pop)  rdPtr_q <= (rdPtr_q == AW'(pTXFIFO_DEPTH - 1)) ? '0 : rdPtr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Frame decisions happen only at the last phase so a frame is never cut short.
  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    trainCnt_d = trainCnt_q;
    frame_d    = frame_q;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ph_d       = '0;
        trainCnt_d = '0;
        frame_d    = '0;
        if (txen_ctl) begin
          state_d = ST_TRAIN;
          frame_d = trainFrame;
        end
      end
      ST_TRAIN, ST_RUN: begin
        ph_d = ph_q + PW'(1);
        if (boundary) begin
          if (!txen_ctl) begin
            state_d = ST_IDLE;
            ph_d    = '0;
            frame_d = '0;
          end else if (state_q == ST_TRAIN && trainCnt_q != CW'(pTRAIN_FRAMES - 1)) begin
            trainCnt_d = trainCnt_q + CW'(1);
            frame_d    = trainFrame;
          end else begin
            state_d = ST_RUN;
            if (!empty && remote_tready) begin
              pop     = 1'b1;
              frame_d = makeFrame(mem_q[rdPtr_q], 1'b1, local_rx_ready);
            end else begin
              frame_d = makeFrame('0, 1'b0, local_rx_ready);
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        ph_d    = '0;
        frame_d = '0;
      end
    endcase
  end

  always_ff @(posedge ioclk) begin
    if (axis_rst) begin
      state_q    <= ST_IDLE;
      ph_q       <= '0;
      trainCnt_q <= '0;
      frame_q    <= '0;
      frameCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      trainCnt_q <= trainCnt_d;
      frame_q    <= frame_d;
      if (pop) frameCnt_q <= frameCnt_q + 32'd1;
    end
  end

  logic [pCLK_RATIO-1:0]      strbPad, keepPad, iduPad;
  logic [pSERIALIO_WIDTH-1:0] phaseLanes [pCLK_RATIO];

  assign strbPad = pCLK_RATIO'(frame_q.beat.strb);
  assign keepPad = pCLK_RATIO'(frame_q.beat.keep);
  assign iduPad  = pCLK_RATIO'(frame_q.beat.idu);

  // Lane order: data lanes, then tstrb, tkeep, tid/tuser, fc.
  always_comb begin
    for (int p = 0; p < pCLK_RATIO; p++) begin
      phaseLanes[p] = '0;
      for (int j = 0; j < NL; j++) phaseLanes[p][j] = frame_q.beat.data[j*pCLK_RATIO+p];
      phaseLanes[p][NL]   = strbPad[p];
      phaseLanes[p][NL+1] = keepPad[p];
      phaseLanes[p][NL+2] = iduPad[p];
    end
    phaseLanes[0][NL+3]            = frame_q.ready;
    phaseLanes[1][NL+3]            = frame_q.valid;
    phaseLanes[2][NL+3]            = frame_q.beat.last;
    phaseLanes[pCLK_RATIO-1][NL+3] = frame_q.parity;
  end

  assign serial_txd   = (state_q == ST_IDLE) ? '0 : phaseLanes[ph_q];
  assign txen         = (state_q != ST_IDLE);
  assign link_state   = state_q;
  assign tx_frame_cnt = frameCnt_q;

endmodule
